// File: rtl/uart_mem_master_pkg.sv
// Shared constants and FSM encoding for the UART-driven memory bus initiator.
package uart_mem_master_pkg;

    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] RSP_ACK   = 8'h06;
    localparam logic [7:0] RSP_NAK   = 8'h15;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        WDATA,
        WREQ,
        RREQ,
        WAIT,
        RSEND,
        RESP
    } state_t;

endpackage

// File: rtl/uart_mem_master.sv
// Turns a UART byte command stream into 32-bit word accesses on the mem bus and
// returns read data plus an ACK/NAK status byte through the UART transmitter.
module uart_mem_master
    import uart_mem_master_pkg::*;
#(
    parameter int unsigned RX_TIMEOUT  = 1_000_000,
    parameter int unsigned BUS_TIMEOUT = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        rx_valid_i,
    input  logic [7:0]  rx_data_i,
    output logic        rx_ready_o,
    output logic        tx_valid_o,
    output logic [7:0]  tx_data_o,
    input  logic        tx_ready_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_rvalid_i,
    input  logic        mem_err_i,
    input  logic [31:0] mem_rdata_i,
    output logic        busy_o
);

    localparam int unsigned RXT_W = $clog2(RX_TIMEOUT + 1);
    localparam int unsigned BST_W = $clog2(BUS_TIMEOUT + 1);

    state_t             r_state, w_state_n;
    logic               r_cmd_write, w_cmd_write_n;
    logic [2:0]         r_cnt, w_cnt_n;
    logic [31:0]        r_addr, w_addr_n;
    logic [15:0]        r_len, w_len_n;
    logic [31:0]        r_wdata, w_wdata_n;
    logic [31:0]        r_rdata, w_rdata_n;
    logic               r_err, w_err_n;
    logic [RXT_W-1:0]   r_rx_timer, w_rx_timer_n;
    logic [BST_W-1:0]   r_bus_timer, w_bus_timer_n;
    logic               r_tx_valid, w_tx_valid_n;
    logic [7:0]         r_tx_data, w_tx_data_n;
    logic               r_rx_ready, r_busy, r_req, r_we;

    logic               w_rx_fire, w_tx_fire, w_rx_expired, w_bus_expired;
    logic [15:0]        w_len_full;

    assign w_rx_fire     = rx_valid_i & r_rx_ready;
    assign w_tx_fire     = r_tx_valid & tx_ready_i;
    assign w_rx_expired  = (r_rx_timer == RXT_W'(RX_TIMEOUT - 1));
    assign w_bus_expired = (r_bus_timer == BST_W'(BUS_TIMEOUT - 1));
    assign w_len_full    = {rx_data_i, r_len[7:0]};

    assign rx_ready_o  = r_rx_ready;
    assign tx_valid_o  = r_tx_valid;
    assign tx_data_o   = r_tx_data;
    assign mem_req_o   = r_req;
    assign mem_addr_o  = r_addr;
    assign mem_we_o    = r_we;
    assign mem_be_o    = 4'hF;
    assign mem_wdata_o = r_wdata;
    assign busy_o      = r_busy;

    // Next-state and datapath update
    always_comb begin
        w_state_n     = r_state;
        w_cmd_write_n = r_cmd_write;
        w_cnt_n       = r_cnt;
        w_addr_n      = r_addr;
        w_len_n       = r_len;
        w_wdata_n     = r_wdata;
        w_rdata_n     = r_rdata;
        w_err_n       = r_err;
        w_tx_valid_n  = r_tx_valid;
        w_tx_data_n   = r_tx_data;
        w_rx_timer_n  = '0;
        w_bus_timer_n = '0;

        case (r_state)
            IDLE: begin
                if (w_rx_fire) begin
                    if (rx_data_i == CMD_WRITE || rx_data_i == CMD_READ) begin
                        w_state_n     = HDR;
                        w_cmd_write_n = (rx_data_i == CMD_WRITE);
                        w_cnt_n       = 3'd0;
                        w_err_n       = 1'b0;
                    end else begin
                        w_state_n = RESP;
                        w_err_n   = 1'b1;
                    end
                end
            end
            HDR: begin
                if (w_rx_fire) begin
                    case (r_cnt)
                        3'd0:    w_addr_n[7:0]   = {rx_data_i[7:2], 2'b00};
                        3'd1:    w_addr_n[15:8]  = rx_data_i;
                        3'd2:    w_addr_n[23:16] = rx_data_i;
                        3'd3:    w_addr_n[31:24] = rx_data_i;
                        3'd4:    w_len_n[7:0]    = rx_data_i;
                        default: w_len_n[15:8]   = rx_data_i;
                    endcase
                    w_cnt_n = r_cnt + 3'd1;
                    if (r_cnt == 3'd5) begin
                        w_cnt_n = 3'd0;
                        if (w_len_full == 16'd0)
                            w_state_n = RESP;
                        else
                            w_state_n = r_cmd_write ? WDATA : RREQ;
                    end
                end else if (w_rx_expired) begin
                    w_state_n = RESP;
                    w_err_n   = 1'b1;
                end else begin
                    w_rx_timer_n = r_rx_timer + RXT_W'(1);
                end
            end
            WDATA: begin
                if (w_rx_fire) begin
                    w_wdata_n[{r_cnt[1:0], 3'b000} +: 8] = rx_data_i;
                    w_cnt_n = r_cnt + 3'd1;
                    if (r_cnt == 3'd3) begin
                        w_cnt_n   = 3'd0;
                        w_state_n = WREQ;
                    end
                end else if (w_rx_expired) begin
                    w_state_n = RESP;
                    w_err_n   = 1'b1;
                end else begin
                    w_rx_timer_n = r_rx_timer + RXT_W'(1);
                end
            end
            WREQ, RREQ: begin
                w_state_n = WAIT;
            end
            WAIT: begin
                // A timed-out access completes like an errored one; rvalid wins a tie
                if (mem_rvalid_i || w_bus_expired) begin
                    if (!mem_rvalid_i || mem_err_i)
                        w_err_n = 1'b1;
                    if (!r_cmd_write)
                        w_rdata_n = mem_rvalid_i ? mem_rdata_i : 32'hFFFF_FFFF;
                    w_len_n  = r_len - 16'd1;
                    w_addr_n = r_addr + 32'd4;
                    w_cnt_n  = 3'd0;
                    if (r_cmd_write)
                        w_state_n = (r_len == 16'd1) ? RESP : WDATA;
                    else
                        w_state_n = RSEND;
                end else begin
                    w_bus_timer_n = r_bus_timer + BST_W'(1);
                end
            end
            RSEND: begin
                if (w_tx_fire) begin
                    if (r_cnt == 3'd3) begin
                        w_tx_valid_n = 1'b0;
                        w_cnt_n      = 3'd0;
                        w_state_n    = (r_len == 16'd0) ? RESP : RREQ;
                    end else begin
                        w_cnt_n     = r_cnt + 3'd1;
                        w_tx_data_n = r_rdata[{2'(r_cnt[1:0] + 2'd1), 3'b000} +: 8];
                    end
                end
            end
            RESP: begin
                if (w_tx_fire) begin
                    w_tx_valid_n = 1'b0;
                    w_state_n    = IDLE;
                end
            end
            default: begin
                w_state_n = IDLE;
            end
        endcase

        if (w_state_n == RSEND && r_state != RSEND) begin
            w_tx_valid_n = 1'b1;
            w_tx_data_n  = w_rdata_n[7:0];
        end
        if (w_state_n == RESP && r_state != RESP) begin
            w_tx_valid_n = 1'b1;
            w_tx_data_n  = w_err_n ? RSP_NAK : RSP_ACK;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= IDLE;
            r_cmd_write <= 1'b0;
            r_cnt       <= 3'd0;
            r_addr      <= 32'd0;
            r_len       <= 16'd0;
            r_wdata     <= 32'd0;
            r_rdata     <= 32'd0;
            r_err       <= 1'b0;
            r_rx_timer  <= '0;
            r_bus_timer <= '0;
            r_tx_valid  <= 1'b0;
            r_tx_data   <= 8'd0;
            r_rx_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_req       <= 1'b0;
            r_we        <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_cmd_write <= w_cmd_write_n;
            r_cnt       <= w_cnt_n;
            r_addr      <= w_addr_n;
            r_len       <= w_len_n;
            r_wdata     <= w_wdata_n;
            r_rdata     <= w_rdata_n;
            r_err       <= w_err_n;
            r_rx_timer  <= w_rx_timer_n;
            r_bus_timer <= w_bus_timer_n;
            r_tx_valid  <= w_tx_valid_n;
            r_tx_data   <= w_tx_data_n;
            r_rx_ready  <= (w_state_n == IDLE) || (w_state_n == HDR) || (w_state_n == WDATA);
            r_busy      <= (w_state_n != IDLE);
            r_req       <= (w_state_n == WREQ) || (w_state_n == RREQ);
            r_we        <= (w_state_n == WREQ);
        end
    end

endmodule
